// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Session-based arbiter for the shared packet/table memory port. Each
// requester raises req_i[k] and keeps it high for a whole session. While it
// owns the port, its memory bus is muxed onto the memory outputs. Dropping
// req_i ends the session. Ownership passes round-robin, and there is always
// one idle turnaround cycle (TURN) between owners.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req_i           per-requester session request
//   gnt_o           registered one-hot grant
//   rq_ce_i/we_i    per-requester chip/write enable
//   rq_addr_i       packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rq_width_i      packed 4-bit byte-width fields
//   rq_data_i       packed write data
//   mem_*_o         command to memory; all zero unless a session is active
//   busy_o          a grant is active
//   owner_o         index of the current or most recent owner
//   overrun_o       one-cycle pulse when the owner has held the port for
//                   MAX_HOLD cycles while somebody else is waiting
//
// Memory read data is broadcast to the requesters outside this block.

module mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic [NUM_REQ-1:0]            rq_ce_i,
    input  logic [NUM_REQ-1:0]            rq_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr_i,
    input  logic [NUM_REQ*4-1:0]          rq_width_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] rq_data_i,
    output logic                          mem_ce_o,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [3:0]                    mem_width_o,
    output logic [DATA_WIDTH-1:0]         mem_data_o,
    output logic                          busy_o,
    output logic [2:0]                    owner_o,
    output logic                          overrun_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        TURN
    } state_t;

    state_t            state;
    logic [IW-1:0]     owner_idx;
    logic [IW-1:0]     rr_ptr;
    logic [HW-1:0]     hold_cnt;
    logic              ov_done;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [HW-1:0]     hold_next;
    logic [NUM_REQ-1:0] own_mask;
    logic              others_req;
    logic              active;

    assign owner_o = 3'(owner_idx);

    // Round-robin search: the first requesting index at or after rr_ptr,
    // wrapping around. rr_ptr always sits one past the most recent owner,
    // so that owner has the lowest priority in the next round.
    always_comb begin
        int j;
        pick_valid = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!pick_valid && req_i[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    // Saturating hold count and "someone else is waiting" detection, used
    // to decide when an overrun is reported.
    always_comb begin
        hold_next  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        own_mask   = NUM_REQ'(1) << owner_idx;
        others_req = |(req_i & ~own_mask);
    end

    // Session state machine. The grant, busy flag, owner index and overrun
    // pulse are all registered here. A new session clears the hold counter,
    // so hold_cnt == 0 also marks the first cycle of ownership. The write
    // gate below relies on that. An overrun is flagged only once per
    // session, and ownership is never taken away.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_o     <= '0;
            busy_o    <= 1'b0;
            owner_idx <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            ov_done   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_o     <= NUM_REQ'(1) << pick_idx;
                        busy_o    <= 1'b1;
                        owner_idx <= pick_idx;
                        rr_ptr    <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                        hold_cnt  <= '0;
                        ov_done   <= 1'b0;
                        state     <= OWNED;
                    end
                end
                OWNED: begin
                    if (!req_i[owner_idx]) begin
                        gnt_o  <= '0;
                        busy_o <= 1'b0;
                        state  <= TURN;
                    end else begin
                        hold_cnt <= hold_next;
                        if (hold_next == HOLD_MAX && others_req && !ov_done) begin
                            overrun_o <= 1'b1;
                            ov_done   <= 1'b1;
                        end
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory command mux. Only the owner's bus reaches memory, and only
    // while a session is active. Reset releases the port straight away
    // instead of waiting for the registered state to clear. Writes are
    // suppressed in the first owned cycle, so a requester that drives
    // its bus early cannot slip a stray write in.
    always_comb begin
        active      = (state == OWNED) && !rst;
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_width_o = '0;
        mem_data_o  = '0;
        if (active) begin
            mem_ce_o    = rq_ce_i[owner_idx];
            mem_we_o    = rq_we_i[owner_idx] && (hold_cnt != '0);
            mem_addr_o  = rq_addr_i[owner_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_width_o = rq_width_i[owner_idx*4 +: 4];
            mem_data_o  = rq_data_i[owner_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (4 requesters, MAX_HOLD = 8). A
// session-level reference model tracks the current owner, the remaining
// turnaround gap, the round-robin start point and how long the owner has
// held the port. Every cycle, the DUT outputs are compared against the
// expectations from that model. Directed scenarios come first, followed by
// a randomized run.

module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MH = 8;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      gnt;
    logic [N-1:0]      ce;
    logic [N-1:0]      we;
    logic [N*AW-1:0]   addr;
    logic [N*4-1:0]    width;
    logic [N*DW-1:0]   data;
    logic              mem_ce;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [3:0]        mem_width;
    logic [DW-1:0]     mem_data;
    logic              busy;
    logic [2:0]        owner;
    logic              overrun;

    int vectors;
    int miscompares;

    // Reference model state, in session terms
    int m_owner;    // -1 when no session is active
    int m_gap;      // turnaround cycles still to pass before arbitration
    int m_start;    // first index searched on the next arbitration
    int m_last;     // most recent owner
    int m_hold;     // saturating count of cycles held
    int m_age;      // cycles since grant (0 = grant cycle)
    bit m_ov;
    bit m_ovdone;

    mem_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt),
        .rq_ce_i(ce), .rq_we_i(we), .rq_addr_i(addr), .rq_width_i(width),
        .rq_data_i(data), .mem_ce_o(mem_ce), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_width_o(mem_width), .mem_data_o(mem_data),
        .busy_o(busy), .owner_o(owner), .overrun_o(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_owner = -1; m_gap = 0; m_start = 0; m_last = 0;
        m_hold = 0; m_age = 0; m_ov = 1'b0; m_ovdone = 1'b0;
    endtask

    // Advance the model by one clock using the inputs sampled at the edge
    task automatic modelStep();
        if (rst) begin
            modelReset();
        end else begin
            m_ov = 1'b0;
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_owner = -1;
                    m_gap   = 1;
                end else begin
                    m_age++;
                    if (m_hold < MH) m_hold++;
                    if (m_hold == MH && (req & ~(4'b1 << m_owner)) != 0 && !m_ovdone) begin
                        m_ov     = 1'b1;
                        m_ovdone = 1'b1;
                    end
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_start + i) % N;
                    if (m_owner < 0 && req[k]) begin
                        m_owner  = k;
                        m_last   = k;
                        m_start  = (k + 1) % N;
                        m_hold   = 0;
                        m_age    = 0;
                        m_ovdone = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0] e_gnt;
        logic         act;
        e_gnt = (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0;
        act   = (m_owner >= 0) && !rst;
        chk("gnt",     32'(gnt),     32'(e_gnt));
        chk("busy",    32'(busy),    32'(m_owner >= 0));
        chk("owner",   32'(owner),   32'(m_last));
        chk("overrun", 32'(overrun), 32'(m_ov));
        chk("mem_ce",  32'(mem_ce),  act ? 32'(ce[m_owner]) : 32'd0);
        chk("mem_we",  32'(mem_we),  (act && m_age > 0) ? 32'(we[m_owner]) : 32'd0);
        chk("mem_addr",  mem_addr,        act ? addr[m_owner*AW +: AW] : 32'd0);
        chk("mem_width", 32'(mem_width),  act ? 32'(width[m_owner*4 +: 4]) : 32'd0);
        chk("mem_data",  mem_data,        act ? data[m_owner*DW +: DW] : 32'd0);
    endtask

    // Inputs are set by the caller just after a falling edge. This task
    // checks the settled outputs, takes one rising edge, and advances the
    // model before returning at the next falling edge.
    task automatic applyStimulus();
        #1;
        checkOutput();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic randomBus();
        ce = N'($urandom);
        we = N'($urandom);
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW]  = $urandom;
            width[k*4 +: 4]   = 4'($urandom);
            data[k*DW +: DW]  = $urandom;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = '0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
    endtask

    initial begin
        int got[5];
        int n_got;
        int exp_order[5];
        int pulses;
        logic prev_busy;

        vectors = 0;
        miscompares = 0;
        rst = 1'b1; req = '0; ce = '0; we = '0; addr = '0; width = '0; data = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        doReset();

        // Single requester
        ce = 4'b0001;
        addr[0*AW +: AW] = 32'h40;
        req = 4'b0001;
        applyStimulus();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_addr", mem_addr, 32'h40);
        chk("single_ce", 32'(mem_ce), 32'h1);
        repeat (3) applyStimulus();
        req = '0;
        repeat (3) applyStimulus();

        // Round-robin with 4-cycle sessions
        doReset();
        $display("[TB] round-robin phase");
        ce = 4'b1111;
        exp_order = '{0, 1, 2, 3, 0};
        n_got = 0;
        prev_busy = busy;
        for (int c = 0; c < 34; c++) begin
            req = 4'b1111;
            if (m_owner >= 0 && m_age == 3) req[m_owner] = 1'b0;
            applyStimulus();
            if (busy && !prev_busy && n_got < 5) begin
                got[n_got] = int'(owner);
                n_got++;
            end
            prev_busy = busy;
        end
        chk("rr_count", 32'(n_got), 32'd5);
        for (int i = 0; i < n_got; i++) chk("rr_order", 32'(got[i]), 32'(exp_order[i]));

        // Isolation: requester 2 tries to write 0x80 while requester 1 owns
        doReset();
        ce = 4'b0110; we = 4'b0100;
        addr[1*AW +: AW] = 32'h10;
        addr[2*AW +: AW] = 32'h80;
        req = 4'b0010;
        applyStimulus();
        req = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            chk("iso_addr", mem_addr, 32'h10);
            chk("iso_we", 32'(mem_we), 32'h0);
        end
        req = 4'b0100;
        repeat (4) applyStimulus();
        req = '0;
        repeat (3) applyStimulus();

        // Early-write gate
        doReset();
        ce = 4'b0001; we = 4'b0001;
        req = 4'b0001;
        applyStimulus();
        chk("early_gnt", 32'(gnt), 32'h1);
        chk("early_we0", 32'(mem_we), 32'h0);
        applyStimulus();
        chk("early_we1", 32'(mem_we), 32'h1);
        req = '0;
        repeat (3) applyStimulus();

        // Overrun: requester 0 holds 20 cycles while requester 1 waits
        doReset();
        randomBus();
        req = 4'b0011;
        pulses = 0;
        for (int c = 0; c < 21; c++) begin
            applyStimulus();
            if (overrun) pulses++;
        end
        chk("ovr_pulses", 32'(pulses), 32'd1);
        chk("ovr_gnt", 32'(gnt), 32'h1);
        req = 4'b0010;
        repeat (4) applyStimulus();
        req = '0;
        repeat (4) applyStimulus();

        // Reset mid-session while requester 3 owns
        doReset();
        ce = 4'b1111;
        req = 4'b1000;
        repeat (3) applyStimulus();
        chk("mid_owner", 32'(owner), 32'd3);
        rst = 1'b1;
        req = 4'b1001;
        applyStimulus();
        chk("mid_gnt", 32'(gnt), 32'h0);
        chk("mid_ce", 32'(mem_ce), 32'h0);
        rst = 1'b0;
        applyStimulus();
        chk("mid_first", 32'(gnt), 32'h1);
        req = '0;
        repeat (3) applyStimulus();

        // Randomized sessions with occasional resets
        $display("[TB] random phase");
        for (int c = 0; c < 800; c++) begin
            randomBus();
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < N; k++) begin
                if (m_owner == k)
                    req[k] = ($urandom_range(0, 5) != 0);
                else if (!req[k])
                    req[k] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single packet/table memory port between up to `NUM_REQ` processing engines, such as several `proc` pipelines plus the control-plane table loader. Each engine holds ownership for a whole session: request, grant, any number of memory accesses, release. Ownership passes round-robin with a one-cycle turnaround between owners. The arbiter sits between the requesters' memory buses and the memory, and muxes the granted requester's command onto the memory port.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `MAX_HOLD`, default 1024: hold-cycle threshold for overrun reporting, ≥1.

Ports (reset is `rst`, synchronous, active-high; clock is `clk`):
- `clk`  in  1: clock.
- `rst`  in  1: synchronous active-high reset.
- `req_i`  in  NUM_REQ: per-requester session request, held high for the whole session.
- `gnt_o`  out  NUM_REQ: one-hot grant, registered.
- `rq_ce_i`  in  NUM_REQ: per-requester memory chip enable.
- `rq_we_i`  in  NUM_REQ: per-requester write enable.
- `rq_addr_i`  in  NUM_REQ*ADDR_WIDTH: packed addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `rq_width_i`  in  NUM_REQ*4: packed byte-width fields.
- `rq_data_i`  in  NUM_REQ*DATA_WIDTH: packed write data.
- `mem_ce_o`, `mem_we_o`  out  1: to memory.
- `mem_addr_o`  out  ADDR_WIDTH: to memory.
- `mem_width_o`  out  4: to memory.
- `mem_data_o`  out  DATA_WIDTH: to memory.
- `busy_o`  out  1: a grant is active.
- `owner_o`  out  3: index of the current or last owner.
- `overrun_o`  out  1: one-cycle pulse, see Operation.

Memory read data is not routed through this block. It is broadcast to all requesters externally.

## Operation
- State machine states: IDLE, OWNED, TURN.
- Reset values: state IDLE, `gnt_o` 0, `busy_o` 0, `owner_o` 0, `overrun_o` 0. The round-robin pointer is set so that requester 0 has highest priority. The hold counter is 0.
- IDLE:
  - If any `req_i` bit is set, pick the first set bit at or after `(owner_o+1) mod NUM_REQ`. After reset the search starts at 0.
  - Register the one-hot grant into `gnt_o`, load `owner_o`, set `busy_o`, go to OWNED.
- OWNED:
  - The memory outputs are combinationally muxed from requester `owner_o`.
  - When `req_i[owner_o]` is seen low, clear `gnt_o` and `busy_o` and go to TURN.
- TURN: lasts exactly one cycle, then returns to IDLE. Arbitration happens in IDLE.
- Memory outputs when not in OWNED:
  - `mem_ce_o` and `mem_we_o` are 0.
  - `mem_addr_o`, `mem_width_o` and `mem_data_o` are 0.
- Non-granted requesters: their `rq_ce_i`/`rq_we_i` are ignored and never reach memory.
- Grant-cycle protection: `mem_we_o` is also gated to 0 in the cycle `gnt_o` first rises. This prevents a stray write from a requester that drives its bus early.
- Hold counter:
  - Counts cycles in OWNED and saturates at `MAX_HOLD`.
  - Clears on entry to OWNED.
  - `overrun_o` pulses for one cycle when the counter reaches `MAX_HOLD` while another `req_i` bit is set.
  - At most one pulse per session. Ownership is never revoked.
- Simultaneous events:
  - Owner release and a new request in the same cycle: the release is handled first. The new request is granted on the cycle after TURN.
  - The owner re-raising `req_i` during TURN is treated as a fresh request at lowest round-robin priority.
- Reset mid-session: `gnt_o` drops the next cycle and the memory is released immediately. A requester whose grant disappears must restart its session.

## Timing
- `req_i` high at edge t, from IDLE → `gnt_o` high after edge t+1.
- The owner's bus reaches memory combinationally from that cycle. Writes are usable from the following cycle because of grant-cycle gating.
- `req_i[owner]` low at edge t → `gnt_o` low after t+1 (TURN), back in IDLE after t+2, next grant after t+3.
- Minimum spacing between successive grants to different requesters: 3 cycles.
- Fairness: a waiting requester is granted within `NUM_REQ-1` sessions.

## Test plan
- Single requester: `req_i`=0001 at cycle 2 → `gnt_o`=0001 at cycle 3, `busy_o`=1, `owner_o`=0. `rq_addr` 0x40 with `rq_ce` 1 → `mem_addr_o`=0x40, `mem_ce_o`=1.
- Round-robin: `req_i`=1111 held, each owner releases after 4 cycles → grant order 0,1,2,3,0. Each handover shows exactly one TURN cycle with `mem_ce_o`=0.
- Isolation: requester 2 drives `rq_ce`=1, `rq_we`=1 to 0x80 while 1 owns → `mem_addr_o` follows requester 1 and there is no write to 0x80.
- Early-write gate: requester 0 drives `we`=1 in the same cycle its `gnt_o` rises → `mem_we_o`=0 that cycle and 1 on the next.
- Overrun: `MAX_HOLD`=8, requester 0 holds 20 cycles while `req_i[1]`=1 → `overrun_o` pulses once at hold count 8, `gnt_o` remains 0001.
- Reset mid-session: assert `rst` while requester 3 owns → after the next edge `gnt_o`=0, `mem_ce_o`=0. After reset, with `req_i`=1001, requester 0 is granted first.
